// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS debug state-dump engine.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_HDR,
        ST_LOAD,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } dbg_state_e;

    localparam logic [7:0]  DBG_HDR  = 8'hA5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DM_AW    = 10;
    // Word index spans 32 registers plus up to 1024 dmem words.
    localparam int unsigned IDX_W    = 11;

endpackage

// File: rtl/dbg_word_serializer.sv
// Splits a loaded 32-bit word into four big-endian bytes and keeps a running XOR checksum.
module dbg_word_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        csum_clr,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        byte_ready,
    output logic        byte_valid,
    output logic [7:0]  next_byte,
    output logic        last_byte,
    output logic [7:0]  next_csum
);

    logic [31:0] sreg_q, sreg_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        full_q, full_d;
    logic [7:0]  csum_q, csum_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        csum_d = csum_q;
        if (csum_clr) begin
            csum_d = '0;
        end
        if (load) begin
            sreg_d = load_data;
            cnt_d  = '0;
            full_d = 1'b1;
        end else if (full_q && byte_ready) begin
            csum_d = csum_q ^ sreg_q[31:24];
            sreg_d = {sreg_q[23:0], 8'h00};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            csum_q <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            csum_q <= csum_d;
        end
    end

    // Next-state views let the owner register tx_data without an extra cycle.
    assign byte_valid = full_q;
    assign next_byte  = sreg_d[31:24];
    assign last_byte  = (cnt_q == 2'd3);
    assign next_csum  = csum_d;

endmodule

// File: rtl/mips_state_dump.sv
// Freezes the core, reads register file plus a dmem window, and streams a framed byte dump.
module mips_state_dump
    import mips_dbg_pkg::*;
#(
    parameter int unsigned DM_BASE     = 0,
    parameter int unsigned DM_WORDS    = 8,
    parameter int unsigned HALT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        cpu_halt,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [9:0]  dm_raddr,
    input  logic [31:0] dm_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned DRAIN_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(HALT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_REGS   = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0]   IDX_END    = IDX_W'(NUM_REGS + DM_WORDS);
    localparam logic [DM_AW-1:0]   DM_BASE_A  = DM_AW'(DM_BASE);
    localparam logic [DM_AW-1:0]   DM_REGS_A  = DM_AW'(NUM_REGS);

    dbg_state_e            state_q, state_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  halt_q, halt_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;

    logic                  tx_fire;
    logic                  ser_clr, ser_load, ser_ready, ser_valid, ser_last;
    logic [31:0]           ser_word;
    logic [7:0]            ser_next_byte, ser_next_csum;

    assign tx_fire   = tx_valid_q && tx_ready;
    assign ser_ready = (state_q == ST_SEND) && tx_ready;

    dbg_word_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .csum_clr   (ser_clr),
        .load       (ser_load),
        .load_data  (ser_word),
        .byte_ready (ser_ready),
        .byte_valid (ser_valid),
        .next_byte  (ser_next_byte),
        .last_byte  (ser_last),
        .next_csum  (ser_next_csum)
    );

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        idx_d    = idx_q;
        ser_clr  = 1'b0;
        ser_load = 1'b0;
        ser_word = '0;
        rf_raddr = '0;
        dm_raddr = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_HDR;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_HDR: begin
                if (tx_fire) begin
                    idx_d   = '0;
                    ser_clr = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ser_load = 1'b1;
                if (idx_q < IDX_REGS) begin
                    rf_raddr = idx_q[4:0];
                    ser_word = rf_rdata;
                end else begin
                    // (idx - 32) mod 1024 only needs the low address bits.
                    dm_raddr = DM_BASE_A + idx_q[DM_AW-1:0] - DM_REGS_A;
                    ser_word = dm_rdata;
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (ser_valid && tx_fire && ser_last) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q + 1'b1 == IDX_END) ? ST_CSUM : ST_LOAD;
                end
            end
            ST_CSUM: begin
                if (tx_fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        halt_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        tx_valid_d = (state_d == ST_HDR) || (state_d == ST_SEND) || (state_d == ST_CSUM);
        unique case (state_d)
            ST_HDR:  tx_data_d = DBG_HDR;
            ST_SEND: tx_data_d = ser_next_byte;
            ST_CSUM: tx_data_d = ser_next_csum;
            default: tx_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            halt_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            halt_q     <= halt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cpu_halt = halt_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_mips_state_dump.sv
// Scoreboard bench for mips_state_dump: default instance plus a wrapped dmem-window instance.
module tb_mips_state_dump;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        tx_ready = 1'b1;
    logic        busy, done, cpu_halt, tx_valid;
    logic [4:0]  rf_raddr;
    logic [9:0]  dm_raddr;
    logic [31:0] rf_rdata, dm_rdata;
    logic [7:0]  tx_data;

    logic        start2 = 1'b0;
    logic        tx_ready2 = 1'b1;
    logic        busy2, done2, cpu_halt2, tx_valid2;
    logic [4:0]  rf_raddr2;
    logic [9:0]  dm_raddr2;
    logic [31:0] rf_rdata2, dm_rdata2;
    logic [7:0]  tx_data2;

    logic [31:0] regs [32];
    logic [31:0] dmem [1024];

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    logic [7:0] got_q[$];
    logic [7:0] got2_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_rdata  = regs[rf_raddr];
    assign dm_rdata  = dmem[dm_raddr];
    assign rf_rdata2 = regs[rf_raddr2];
    assign dm_rdata2 = dmem[dm_raddr2];

    mips_state_dump dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .cpu_halt(cpu_halt), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dm_raddr(dm_raddr), .dm_rdata(dm_rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    mips_state_dump #(.DM_BASE(1022), .DM_WORDS(4), .HALT_CYCLES(4)) dut_w (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .cpu_halt(cpu_halt2), .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2),
        .dm_raddr(dm_raddr2), .dm_rdata(dm_rdata2), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int unsigned base, input int unsigned words, input bit to_w);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] w;
        cs = '0;
        if (to_w) exp2_q.push_back(8'hA5); else exp_q.push_back(8'hA5);
        for (int unsigned i = 0; i < 32 + words; i++) begin
            w = (i < 32) ? regs[i] : dmem[(base + i - 32) % 1024];
            for (int k = 3; k >= 0; k--) begin
                b = w[k*8 +: 8];
                cs = cs ^ b;
                if (to_w) exp2_q.push_back(b); else exp_q.push_back(b);
            end
        end
        if (to_w) exp2_q.push_back(cs); else exp_q.push_back(cs);
    endtask

    task automatic clear_state();
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < 1024; i++) dmem[i] = '0;
    endtask

    task automatic randomize_state();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 1024; i++) dmem[i] = $urandom;
    endtask

    // Default-instance monitor: scoreboard pop plus stall stability.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 32'(tx_valid), 32'd1);
                check_eq("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                else check_eq("byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    always @(negedge clk) begin
        if (!reset && tx_valid2 && tx_ready2) begin
            got2_q.push_back(tx_data2);
            if (exp2_q.size() == 0) check_eq("w_sb_underflow", 32'(exp2_q.size()), 32'd1);
            else check_eq("w_byte", 32'(tx_data2), 32'(exp2_q.pop_front()));
        end
    end

    task automatic run_frame(input bit rnd, output int unsigned lat);
        int unsigned c0;
        bit seen;
        got_q.delete();
        push_frame(0, 8, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; c0 = cyc;
        if (rnd) tx_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        if (rnd) tx_ready = 1'($urandom_range(0, 1));
        seen = 1'b0; lat = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1; lat = cyc - c0;
            end else begin
                @(posedge clk); #1;
                if (rnd) tx_ready = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("frame_len", 32'(got_q.size()), 32'd162);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int unsigned lat, c0, d1, d2, n;
        bit seen, hit;

        clear_state();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_halt", 32'(cpu_halt), 32'd0);
        check_eq("rst_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_data", 32'(tx_data), 32'd0);
        check_eq("rst_rfaddr", 32'(rf_raddr), 32'd0);
        check_eq("rst_dmaddr", 32'(dm_raddr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // All-zero state, sink always ready: length, framing and latency.
        run_frame(1'b0, lat);
        check_eq("zero_latency", lat, 32'd207);
        check_eq("zero_first", 32'(got_q[0]), 32'hA5);
        check_eq("zero_last", 32'(got_q[161]), 32'h00);

        clear_state();
        regs[8] = 32'h12345678;
        run_frame(1'b0, lat);
        check_eq("r8_b33", 32'(got_q[33]), 32'h12);
        check_eq("r8_b34", 32'(got_q[34]), 32'h34);
        check_eq("r8_b35", 32'(got_q[35]), 32'h56);
        check_eq("r8_b36", 32'(got_q[36]), 32'h78);
        check_eq("r8_csum", 32'(got_q[161]), 32'h08);

        clear_state();
        regs[16] = 5; regs[17] = 10; regs[8] = 15; dmem[4] = 15;
        run_frame(1'b0, lat);
        check_eq("pp_r16", 32'(got_q[68]), 32'h05);
        check_eq("pp_r17", 32'(got_q[72]), 32'h0A);
        check_eq("pp_r8", 32'(got_q[36]), 32'h0F);
        check_eq("pp_dm4", 32'(got_q[148]), 32'h0F);
        check_eq("pp_csum", 32'(got_q[161]), 32'h0F);

        randomize_state();
        run_frame(1'b1, lat);

        // Wrapped dmem window on the second instance.
        got2_q.delete();
        push_frame(1022, 4, 1'b1);
        @(posedge clk); #1; start2 = 1'b1; c0 = cyc;
        @(posedge clk); #1; start2 = 1'b0;
        seen = 1'b0; lat = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (done2) begin seen = 1'b1; lat = cyc - c0; end
            else begin @(posedge clk); #1; end
        end
        check_eq("w_done_seen", 32'(seen), 32'd1);
        check_eq("w_latency", lat, 32'd187);
        check_eq("w_len", 32'(got2_q.size()), 32'd146);
        check_eq("w_drained", 32'(exp2_q.size()), 32'd0);

        // Reset during SEND of word 10 (two of its bytes already sent).
        got_q.delete();
        push_frame(0, 8, 1'b0);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(posedge clk); #1;
            if (got_q.size() >= 43) hit = 1'b1;
        end
        check_eq("mid_reached", 32'(hit), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        check_eq("mid_halt", 32'(cpu_halt), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_valid", 32'(tx_valid), 32'd0);
        check_eq("mid_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        randomize_state();
        run_frame(1'b0, lat);
        check_eq("post_rst_latency", lat, 32'd207);

        // start held high: back-to-back frames.
        got_q.delete();
        push_frame(0, 8, 1'b0);
        push_frame(0, 8, 1'b0);
        @(posedge clk); #1; start = 1'b1;
        n = 0; d1 = 0; d2 = 0;
        for (int i = 0; i < 2000 && n < 2; i++) begin
            @(negedge clk);
            if (done) begin
                if (n == 0) d1 = cyc; else d2 = cyc;
                n++;
            end
            if (n < 2) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1; start = 1'b0;
        check_eq("b2b_count", n, 32'd2);
        check_eq("b2b_gap", d2 - d1, 32'd208);
        check_eq("b2b_len", 32'(got_q.size()), 32'd324);
        check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("b2b_no_third", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_state_dump.md
# mips_state_dump

Debug readout engine for the pipelined MIPS core. On request it freezes the core, reads all 32 register-file entries plus a configurable data-memory window through dedicated read ports, and streams them out as a framed byte stream over a valid/ready interface. It is the hardware counterpart to bench-side program/memory preloading: it extracts architectural state for checking on silicon or in system-level simulation without hierarchical access.

## Interface
- `DM_BASE`, default 0: first dmem word index dumped, in the range 0..1023.
- `DM_WORDS`, default 8: number of dmem words dumped, in the range 1..1024.
- `HALT_CYCLES`, default 4: drain cycles between asserting `cpu_halt` and the first read.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: dump request pulse; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse after the checksum byte is accepted.
- `cpu_halt` out 1: stalls the core's PC/pipeline while high.
- `rf_raddr` out 5: register-file read address.
- `rf_rdata` in 32: combinational read data for `rf_raddr`.
- `dm_raddr` out 10: dmem word-index read address.
- `dm_rdata` in 32: combinational read data for `dm_raddr`.
- `tx_data` out 8: stream byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the sink accepts the byte; a transfer occurs when `tx_valid` and `tx_ready` are both high.

## Operation
- FSM states: IDLE, DRAIN, HDR, LOAD, SEND, CSUM, DONE.
- IDLE:
  - `start`=1 → DRAIN.
  - `start` is ignored in every other state.
- DRAIN:
  - `cpu_halt`=1.
  - Counts `HALT_CYCLES` cycles, then → HDR.
- HDR:
  - Drives `tx_data`=0xA5 with `tx_valid`=1.
  - On transfer: word index ← 0, checksum ← 0, → LOAD.
- LOAD, one cycle:
  - For word index < 32: `rf_raddr`=index; the shift register latches `rf_rdata`.
  - Otherwise: `dm_raddr`=(`DM_BASE` + index − 32) mod 1024; the shift register latches `dm_rdata`.
  - Then → SEND.
- SEND:
  - Emits the 4 bytes of the latched word, big-endian (bits 31:24 first).
  - Each transferred byte is XORed into the checksum.
  - After the 4th transfer: index+1; if the new index equals 32+`DM_WORDS` → CSUM, else → LOAD.
- CSUM:
  - Drives `tx_data`=checksum, the XOR of every payload byte; the header is excluded.
  - On transfer → DONE.
- DONE:
  - `done`=1 for one cycle, then → IDLE; `cpu_halt` drops in IDLE.
- Frame length: 2 + 4·(32+`DM_WORDS`) bytes, which is 162 with the defaults.
- `cpu_halt` is high in every state except IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `cpu_halt`, `tx_valid` = 0.
  - `tx_data`, `rf_raddr`, `dm_raddr` = 0.
  - Checksum and index counters = 0.
- All outputs are registered, except `rf_raddr` and `dm_raddr`, which are valid during LOAD.
- Latency markers, with `start` high in cycle 0:
  - `busy` and `cpu_halt` rise in cycle 1.
  - The header becomes valid in cycle 1+`HALT_CYCLES`.
- With `tx_ready` tied high:
  - Each word costs 5 cycles (1 LOAD + 4 SEND).
  - Total from `start` to `done` = 1 + `HALT_CYCLES` + 1 + 5·(32+`DM_WORDS`) + 1 cycles.
- Handshake rules:
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` stays stable and `tx_valid` does not drop.
  - `tx_valid` is 0 in IDLE, DRAIN, LOAD and DONE.
- Boundary conditions:
  - The dmem address wraps modulo 1024 when `DM_BASE`+`DM_WORDS` > 1024.
  - Reset asserted mid-dump: the next cycle is IDLE, all outputs take their reset values, and `cpu_halt` is released; no partial `done` pulse is produced.
  - `start` held high continuously: each dump starts on the cycle after the previous DONE, i.e. back-to-back frames.

## Structure
- Package `mips_dbg_pkg`:
  - FSM state enum.
  - `DBG_HDR` = 8'hA5.
  - `NUM_REGS` = 32.
  - `DM_AW` = 10.
- Sub-module `dbg_word_serializer`:
  - Interface: 32-bit load, byte-out valid/ready, running XOR checksum, `last_byte` flag.
  - The top FSM sequences it and handles header and trailer.

## Test plan
- All regs and dmem zero, `tx_ready`=1:
  - 162 bytes are transferred.
  - First byte 0xA5, last byte 0x00.
  - `done` arrives exactly 1+4+1+200+1 = 207 cycles after `start`.
- reg8 = 0x12345678, everything else zero:
  - Bytes 33..36 of the frame are 12 34 56 78.
  - Checksum = 0x08.
- Post-program state (reg16=5, reg17=10, reg8=15, dmem[4]=15), `DM_BASE`=0:
  - Reg and dmem bytes appear at the correct offsets.
  - Checksum = 5^10^15^15 = 0x0F.
- Random `tx_ready` backpressure (50% duty):
  - Byte sequence is identical to the `tx_ready`=1 run.
  - `tx_data` never changes while stalled.
- `DM_BASE`=1022, `DM_WORDS`=4:
  - `dm_raddr` sequence is 1022, 1023, 0, 1.
- Reset asserted during SEND of word 10:
  - Next cycle `cpu_halt`, `busy` and `tx_valid` are 0 with no `done`.
  - A new `start` produces a complete, correct frame.
